// File: rtl/uart_defs_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, divisor width and TX state encoding (UART_TX_PARITY_EN adds PARITY).
package uart_defs_pkg;
  localparam int DIV_W = 16;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int ST_TX_ACTIVE = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_PARITY    = 4;
  localparam int ST_COUNT_LSB = 8;

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} tx_state_e;
`else
  localparam logic PARITY_EN = 1'b0;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;
`endif
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational read port; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: register decode, TX FIFO and serialiser.
// Define UART_TX_PARITY_EN for an even-parity bit between data and stop.
module mmio_uart_tx
  import uart_defs_pkg::*;
#(
  parameter logic [31:0]      BASE_ADDR   = 32'h0000_1000,
  parameter int               FIFO_DEPTH  = 16,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic        hit,
  output logic [31:0] rd_data,
  output logic        tx,
  output logic        busy
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, bit_div_q, bit_div_d, timer_q, timer_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       data_q, data_d;
  logic             ovf_q;
  logic             pop, bit_end, wr;
  logic [1:0]       off;
  logic [7:0]       fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             unused_bits;

  assign unused_bits = ^{func3, addr[1:0], data_in[31:16]};

  assign hit = (addr[31:4] == BASE_ADDR[31:4]) && (MemRead || MemWrite);
  assign wr  = MemWrite && hit;
  assign off = addr[3:2];

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr && (off == OFF_DATA)),
    .wdata_i (data_in[7:0]),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DEFAULT_DIV;
      ovf_q <= 1'b0;
    end else begin
      if (wr && (off == OFF_DIV))
        div_q <= (data_in[15:0] == '0) ? DIV_W'(1) : data_in[15:0];
      // a dropped push only happens when full and nothing leaves this cycle
      if (wr && (off == OFF_DATA) && fifo_full && !pop)
        ovf_q <= 1'b1;
      else if (wr && (off == OFF_STATUS) && data_in[ST_OVF])
        ovf_q <= 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    if (hit) begin
      case (off)
        OFF_STATUS: begin
          rd_data[ST_TX_ACTIVE]         = (state_q != S_IDLE);
          rd_data[ST_FULL]              = fifo_full;
          rd_data[ST_EMPTY]             = fifo_empty;
          rd_data[ST_OVF]               = ovf_q;
          rd_data[ST_PARITY]            = PARITY_EN;
          rd_data[ST_COUNT_LSB +: CW]   = fifo_count;
        end
        OFF_DIV:            rd_data[DIV_W-1:0] = div_q;
        OFF_DATA, OFF_RSVD: rd_data = '0;
      endcase
    end
  end

  assign bit_end = (timer_q == bit_div_q - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q    <= data_d;
    bit_div_q <= bit_div_d;
  end

  // popping again at the end of STOP keeps frames back-to-back
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + DIV_W'(1);
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    bit_div_d = bit_div_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          data_d    = fifo_rdata;
          bit_div_d = div_q;
          state_d   = S_START;
        end
      end
      S_START: if (bit_end) begin
        timer_d   = '0;
        bit_idx_d = '0;
        state_d   = S_DATA;
      end
      S_DATA: if (bit_end) begin
        timer_d   = '0;
        bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
        if (bit_idx_q == 3'd7) state_d = S_PARITY;
`else
        if (bit_idx_q == 3'd7) state_d = S_STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) begin
        timer_d = '0;
        state_d = S_STOP;
      end
`endif
      S_STOP: if (bit_end) begin
        timer_d = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          data_d    = fifo_rdata;
          bit_div_d = div_q;
          state_d   = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      S_START:  tx = 1'b0;
      S_DATA:   tx = data_q[bit_idx_q];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx = ^data_q;
`endif
      default:  tx = 1'b1;
    endcase
  end

  assign busy = (state_q != S_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: a queue-and-frame model predicts tx/busy every
// cycle; literal expectations pin reset values, the 0x55 waveform and STATUS words.
`timescale 1ns/1ps
module tb_mmio_uart_tx;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int          NB   = 11;
  localparam logic [31:0] PBIT = 32'h10;
`else
  localparam int          NB   = 10;
  localparam logic [31:0] PBIT = 32'h0;
`endif

  logic        clk = 1'b0, rst = 1'b1, MemRead = 1'b0, MemWrite = 1'b0;
  logic [2:0]  func3 = 3'b010;
  logic [31:0] addr = '0, data_in = '0;
  logic        hit, tx, busy;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mmio_uart_tx #(.BASE_ADDR(32'h0000_1000), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd868)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .func3(func3),
    .addr(addr), .data_in(data_in), .hit(hit), .rd_data(rd_data), .tx(tx), .busy(busy)
  );

  // Model: a byte queue plus the frame currently on the wire as a list of bit values.
  byte unsigned mq[$];
  byte unsigned mb;
  int  frame_left = 0, fpos = 0, fdiv = 1, div_m = 868;
  bit  ovf_m = 1'b0;
  bit  fbits [11];

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      frame_left = 0;
      fpos       = 0;
      div_m      = 868;
      ovf_m      = 1'b0;
    end else begin
      if (frame_left > 0) begin
        frame_left = frame_left - 1;
        fpos       = fpos + 1;
      end
      if (frame_left == 0 && mq.size() > 0) begin
        mb = mq.pop_front();
        fbits[0] = 1'b0;
        for (int i = 0; i < 8; i++) fbits[i+1] = mb[i];
        fbits[9]    = ^mb;
        fbits[10]   = 1'b1;
        fbits[NB-1] = 1'b1;
        fdiv        = div_m;
        frame_left  = NB * fdiv;
        fpos        = 0;
      end
      if (MemWrite && addr[31:4] == 28'h0000100) begin
        case (addr[3:2])
          2'd0: if (mq.size() < DEPTH) mq.push_back(data_in[7:0]); else ovf_m = 1'b1;
          2'd1: if (data_in[3]) ovf_m = 1'b0;
          2'd2: div_m = (data_in[15:0] == 16'd0) ? 1 : int'(data_in[15:0]);
          default: ;
        endcase
      end
    end
  end

  function automatic logic exp_tx();
    return (frame_left > 0) ? logic'(fbits[fpos / fdiv]) : 1'b1;
  endfunction

  function automatic logic exp_busy();
    return (frame_left > 0) || (mq.size() > 0);
  endfunction

  function automatic logic [31:0] status_exp();
    logic [31:0] s;
    s = PBIT;
    s[0]    = (frame_left > 0);
    s[1]    = (mq.size() == DEPTH);
    s[2]    = (mq.size() == 0);
    s[3]    = ovf_m;
    s[12:8] = 5'(mq.size());
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_cycle", 32'(tx), 32'(exp_tx()));
      chk("busy_cycle", 32'(busy), 32'(exp_busy()));
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic exp_hit);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b1; addr = a; data_in = d;
    #1 chk("wr_hit", 32'(hit), 32'(exp_hit));
  endtask

  task automatic idle();
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0; addr = '0; data_in = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b1; addr = a;
    #1;
    chk({nm, "_hit"}, 32'(hit), 32'd1);
    chk(nm, rd_data, exp);
  endtask

  task automatic rd_status(input logic [31:0] lit, input string nm);
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b1; addr = 32'h0000_1004;
    #1;
    chk({nm, "_model"}, rd_data, status_exp());
    chk({nm, "_lit"}, rd_data, lit);
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while ((busy || exp_busy()) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  logic lit55 [11];
  int   cnt;

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    lit55 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    if (NB == 11) lit55[9] = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("tx_reset", 32'(tx), 32'd1);
    chk("busy_reset", 32'(busy), 32'd0);
    rd_status(32'h0000_0004 | PBIT, "status_reset");
    rd(32'h0000_1008, 32'd868, "div_reset");

    // 0x55 at divisor 4
    wr(32'h0000_1008, 32'd4, 1'b1);
    wr(32'h0000_1000, 32'h55, 1'b1);
    idle();
    chk("tx_before_start", 32'(tx), 32'd1);
    for (int i = 0; i < NB * 4; i++) begin
      @(negedge clk);
      chk("wave55", 32'(tx), 32'(lit55[i / 4]));
    end
    @(negedge clk);
    chk("busy_after55", 32'(busy), 32'd0);

    // fill past full while the first frame is on the wire
    wr(32'h0000_1008, 32'd2, 1'b1);
    for (int i = 0; i < 17; i++) wr(32'h0000_1000, 32'h10 + 32'(i), 1'b1);
    wr(32'h0000_1000, 32'hEE, 1'b1);
    idle();
    rd_status(32'h0000_100B | PBIT, "status_ovf");
    wr(32'h0000_1004, 32'h8, 1'b1);
    rd_status(32'h0000_1003 | PBIT, "status_clr");
    idle();
    wait_idle(1000);

    // divisor 0 is stored as 1
    wr(32'h0000_1008, 32'd0, 1'b1);
    rd(32'h0000_1008, 32'd1, "div_zero");
    wr(32'h0000_1000, 32'hA3, 1'b1);
    idle();
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    chk("a3_len", 32'(cnt), 32'(NB));

    // reset in the middle of 0xFF with three bytes queued
    wr(32'h0000_1008, 32'd4, 1'b1);
    wr(32'h0000_1000, 32'hFF, 1'b1);
    wr(32'h0000_1000, 32'h01, 1'b1);
    wr(32'h0000_1000, 32'h02, 1'b1);
    wr(32'h0000_1000, 32'h03, 1'b1);
    idle();
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("tx_after_rst", 32'(tx), 32'd1);
    chk("busy_after_rst", 32'(busy), 32'd0);
    rd_status(32'h0000_0004 | PBIT, "status_after_rst");
    rd(32'h0000_1008, 32'd868, "div_after_rst");
    idle();
    repeat (30) @(negedge clk);
    chk("quiet_after_rst", 32'(busy), 32'd0);

    // decode window
    wr(32'h0000_2000, 32'h77, 1'b0);
    idle();
    chk("no_push_outside", 32'(busy), 32'd0);
    rd(32'h0000_100C, 32'd0, "rsvd_rd");
    rd(32'h0000_1000, 32'd0, "data_rd");
    idle();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU's data-memory port, downstream of the MEM stage, alongside the unified memory.
- Decodes loads and stores to its address window, buffers store bytes in a FIFO, and serialises them 8N1 on a single TX line.
- Top level muxes its read data onto the memory read path when `hit` is high.

Parameters:
- BASE_ADDR, 32'h0000_1000, window base; 16-byte aligned.
- FIFO_DEPTH, 16, TX FIFO entries; power of two, >= 2.
- DEFAULT_DIV, 16'd868, reset value of the baud divisor (clock cycles per bit).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous reset, active-high.
- MemRead  in  1  load in MEM stage.
- MemWrite  in  1  store in MEM stage.
- func3  in  3  access width; ignored for decode, store uses data_in[7:0] for DATA and data_in[15:0] for DIV.
- addr  in  32  byte address.
- data_in  in  32  store data.
- hit  out  1  combinational; high when addr[31:4]==BASE_ADDR[31:4] and (MemRead|MemWrite).
- rd_data  out  32  combinational register read data; 0 when not hit.
- tx  out  1  serial output; idle high.
- busy  out  1  high while FSM not IDLE or FIFO not empty.

Behaviour:
- Register map, offset = addr[3:2]:
  - 0 DATA: write only; a write pushes a byte; reads return 0.
  - 1 STATUS: read-only except bit3. Bit0 tx_active, bit1 fifo_full, bit2 fifo_empty, bit3 overflow (sticky; write 1 to clear), bits[8+log2(FIFO_DEPTH):8] fifo count.
  - 2 DIV: R/W, bits[15:0]; a write of 0 stores 1.
  - 3: reserved; reads 0, writes ignored.
- Reset values:
  - tx=1, busy=0, FIFO empty (count 0), overflow=0, DIV=DEFAULT_DIV, state IDLE.
  - Reset asserted mid-frame drives tx=1 at that edge and discards the FIFO.
- FIFO:
  - Push on a DATA write.
  - When full, the push is dropped and overflow is set, unless a pop occurs in the same cycle; then the push is accepted and the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Count is FIFO_DEPTH+1 states wide.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO is non-empty, pop into shift register, latch DIV into bit_div, go to START.
  - START: tx=0 for bit_div cycles.
  - DATA: 8 bits LSB first, each held bit_div cycles, bit index counter 0..7.
  - STOP: tx=1 for bit_div cycles, then IDLE. A non-empty FIFO is popped at the STOP→IDLE boundary without an extra idle cycle (back-to-back frames).
  - Bit timer counts 0..bit_div-1. A frame is exactly 10*bit_div cycles.
- Latency: a DATA write captured at edge N; tx falls at edge N+1 when IDLE and FIFO was empty.
- A DIV write mid-frame affects only the next frame.
- Loads have no side effects.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds PARITY state between DATA and STOP, transmitting even parity (XOR of the 8 data bits) for bit_div cycles.
  - Frame is 11*bit_div cycles.
  - STATUS bit4 reads 1, indicating parity is present.
- Undefined: 8N1, and STATUS bit4 reads 0.

Decomposition:
- Shared package (uart_defs): register offsets, STATUS bit indices, FSM state encoding (2 bits, 3 with parity), DIV width.
- Sub-module sync_fifo: parameterised width/depth, push, pop, full, empty, count.
- Decode, register file and TX FSM live in mmio_uart_tx.

Test Plan:
- Reset, then read STATUS → rd_data=0x0000_0004 (empty) and tx=1. Read DIV → 868.
- DIV write 4, DATA write 0x55 → tx low from edge N+1 for 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, then stop high 4 cycles. busy falls after 40 cycles.
- DIV=2, write 17 bytes back-to-back with FIFO_DEPTH=16 while FSM is stalled by first frame → first byte popped immediately so 17 accepted. 18th write sets overflow (STATUS bit3=1). Write STATUS 0x8 → bit3 cleared.
- DIV write 0 → DIV reads 1. Frame of 0xA3 lasts 10 cycles.
- Assert rst mid-DATA of frame 0xFF with 3 bytes queued → tx=1 next cycle, count 0, no further frames.
- Address 0x0000_2000 store → hit=0, no push. Load to 0x100C → hit=1, rd_data=0.
